// File: rtl/common.sv
// Shared core-wide constants and basic scalar types.
package common;

    localparam int XLEN    = 64;
    localparam int REG_NUM = 32;

    typedef logic [63:0] u64;
    typedef logic [4:0]  u5;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: set on issue, cleared on write-back,
// wiped on flush; also produces a registered busy popcount.
module regfile_scoreboard
    import common::*;
#(
    parameter  int NREG = REG_NUM,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr [NRD],
    output logic          rd_busy [NRD],
    input  logic          wr_en   [NWR],
    input  logic [AW-1:0] wr_addr [NWR],
    input  logic          iss_en,
    input  logic [AW-1:0] iss_addr,
    input  logic          flush,
    output logic [AW:0]   busy_cnt
);

    localparam logic [NREG-1:0] NZ_MASK = {{(NREG-1){1'b1}}, 1'b0};

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nx;
    logic [NREG-1:0] wr_vec;
    logic [NREG-1:0] iss_vec;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++)
            c = c + (AW+1)'(v[i]);
        return c;
    endfunction

    always_comb begin
        wr_vec = '0;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p])
                wr_vec[wr_addr[p]] = 1'b1;
    end

    always_comb begin
        iss_vec = '0;
        if (iss_en)
            iss_vec[iss_addr] = 1'b1;
    end

    // Issue is applied after the clear so a same-cycle new producer wins.
    always_comb begin
        busy_nx = (iss_vec | (busy & ~wr_vec)) & NZ_MASK;
        if (flush)
            busy_nx = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nx;
            busy_cnt <= popcount(busy_nx);
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy[rd_addr[i]];
            if (wr_vec[rd_addr[i]] && !iss_vec[rd_addr[i]])
                rd_busy[i] = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with write-to-read bypass
// and an attached issue/write-back scoreboard.
module regfile_mp
    import common::*;
#(
    parameter  int XLEN = common::XLEN,
    parameter  int NREG = REG_NUM,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rd_addr  [NRD],
    output logic [XLEN-1:0] rd_data  [NRD],
    output logic            rd_busy  [NRD],
    input  logic            wr_en    [NWR],
    input  logic [AW-1:0]   wr_addr  [NWR],
    input  logic [XLEN-1:0] wr_data  [NWR],
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            flush,
    output logic [AW:0]     busy_cnt,
    output logic [XLEN-1:0] rf_out   [NREG]
);

    logic [XLEN-1:0] regs [NREG];

    // Ascending port order makes the highest-index port win on collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_addr[p] != '0)
                    regs[wr_addr[p]] <= wr_data[p];
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_data[i] = regs[rd_addr[i]];
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_addr[p] == rd_addr[i] && rd_addr[i] != '0)
                    rd_data[i] = wr_data[p];
        end
    end

    assign rf_out = regs;

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp: bypass, port priority,
// x0 handling, scoreboard set/clear/flush and async reset.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr  [2];
    logic [63:0] rd_data  [2];
    logic        rd_busy  [2];
    logic        wr_en    [2];
    logic [4:0]  wr_addr  [2];
    logic [63:0] wr_data  [2];
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [5:0]  busy_cnt;
    logic [63:0] rf_out   [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt),
        .rf_out   (rf_out)
    );

    typedef struct {
        string       name;
        logic        wen0;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic        wen1;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic        ien;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] rd0;
        logic        rb0;
        logic [63:0] rd1;
        logic        rb1;
        logic [5:0]  cnt;
        logic [4:0]  ca;
        logic [63:0] crf;
    } vec_t;

    vec_t vec [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en[0] = 0; wr_addr[0] = 0; wr_data[0] = 0;
        wr_en[1] = 0; wr_addr[1] = 0; wr_data[1] = 0;
        iss_en = 0; iss_addr = 0; flush = 0;
    endtask

    initial begin
        //          name        wen0 wa0 wd0       wen1 wa1 wd1     ien ia fl ra0 ra1 rd0      rb0 rd1      rb1 cnt ca crf
        vec[0]  = '{"w5_byp",   1, 5, 64'h1234,  0, 0, 0,        0, 0, 0, 5, 0,  64'h1234,0, 0,       0,  0, 5, 64'h1234};
        vec[1]  = '{"w7_prio",  1, 7, 64'hA,     1, 7, 64'hB,    0, 0, 0, 7, 5,  64'hB,   0, 64'h1234,0,  0, 7, 64'hB};
        vec[2]  = '{"x0",       1, 0, 64'hFFFF,  0, 0, 0,        1, 0, 0, 0, 7,  0,       0, 64'hB,   0,  0, 0, 0};
        vec[3]  = '{"iss3",     0, 0, 0,         0, 0, 0,        1, 3, 0, 3, 4,  0,       0, 0,       0,  1, 3, 0};
        vec[4]  = '{"iss4",     0, 0, 0,         0, 0, 0,        1, 4, 0, 3, 4,  0,       1, 0,       0,  2, 3, 0};
        vec[5]  = '{"wr3",      1, 3, 64'h33,    0, 0, 0,        0, 0, 0, 3, 4,  64'h33,  0, 0,       1,  1, 3, 64'h33};
        vec[6]  = '{"iss_wr4",  0, 0, 0,         1, 4, 64'h44,   1, 4, 0, 4, 3,  64'h44,  1, 64'h33,  0,  1, 4, 64'h44};
        vec[7]  = '{"iss1",     0, 0, 0,         0, 0, 0,        1, 1, 0, 1, 4,  0,       0, 64'h44,  1,  2, 1, 0};
        vec[8]  = '{"iss2",     0, 0, 0,         0, 0, 0,        1, 2, 0, 2, 1,  0,       0, 0,       1,  3, 2, 0};
        vec[9]  = '{"iss9",     0, 0, 0,         0, 0, 0,        1, 9, 0, 9, 2,  0,       0, 0,       1,  4, 9, 0};
        vec[10] = '{"flush",    1,10, 64'hAA,    0, 0, 0,        1,10, 1,10, 9,  64'hAA,  0, 0,       1,  0,10, 64'hAA};
        vec[11] = '{"post_fl",  0, 0, 0,         0, 0, 0,        0, 0, 0,10, 4,  64'hAA,  0, 64'h44,  0,  0, 4, 64'h44};

        idle();
        rd_addr[0] = 0; rd_addr[1] = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_cnt", 64'(busy_cnt), 0);
        chk("rst_rf5", rf_out[5], 0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wr_en[0] = vec[i].wen0; wr_addr[0] = vec[i].wa0; wr_data[0] = vec[i].wd0;
            wr_en[1] = vec[i].wen1; wr_addr[1] = vec[i].wa1; wr_data[1] = vec[i].wd1;
            iss_en = vec[i].ien; iss_addr = vec[i].ia; flush = vec[i].fl;
            rd_addr[0] = vec[i].ra0; rd_addr[1] = vec[i].ra1;
            #1;
            chk({vec[i].name, "_rd0"}, rd_data[0], vec[i].rd0);
            chk({vec[i].name, "_rb0"}, 64'(rd_busy[0]), 64'(vec[i].rb0));
            chk({vec[i].name, "_rd1"}, rd_data[1], vec[i].rd1);
            chk({vec[i].name, "_rb1"}, 64'(rd_busy[1]), 64'(vec[i].rb1));
            @(posedge clk);
            #1;
            chk({vec[i].name, "_cnt"}, 64'(busy_cnt), 64'(vec[i].cnt));
            chk({vec[i].name, "_rf"}, rf_out[vec[i].ca], vec[i].crf);
        end

        // Load x8 busy, then async reset mid-cycle.
        @(negedge clk);
        idle();
        wr_en[0] = 1; wr_addr[0] = 8; wr_data[0] = 64'h55;
        iss_en = 1; iss_addr = 8;
        rd_addr[0] = 8;
        @(posedge clk);
        #1;
        chk("x8_load", rf_out[8], 64'h55);
        chk("x8_cnt", 64'(busy_cnt), 1);
        idle();
        #2;
        rst = 1;
        #1;
        chk("arst_rf8", rf_out[8], 0);
        chk("arst_cnt", 64'(busy_cnt), 0);
        chk("arst_rb8", 64'(rd_busy[0]), 0);
        chk("arst_rf4", rf_out[4], 0);

        // Activity during reset must be discarded.
        @(negedge clk);
        wr_en[0] = 1; wr_addr[0] = 8; wr_data[0] = 64'h99;
        iss_en = 1; iss_addr = 8;
        @(posedge clk);
        #1;
        idle();
        rst = 0;
        #1;
        chk("rstw_rf8", rf_out[8], 0);
        chk("rstw_cnt", 64'(busy_cnt), 0);

        // Normal operation resumes at the first edge after reset.
        @(negedge clk);
        wr_en[1] = 1; wr_addr[1] = 6; wr_data[1] = 64'h66;
        iss_en = 1; iss_addr = 12;
        @(posedge clk);
        #1;
        chk("resume_rf6", rf_out[6], 64'h66);
        chk("resume_cnt", 64'(busy_cnt), 1);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
